// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 round controller.
// Optional decrypt key ordering is enabled by defining AES_CTRL_DECRYPT_EN.
package aes_ctrl_pkg;
  localparam int AES128_NR = 10;
  localparam int RND_W_DEF = 4;
  localparam int WCNT_W    = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ROUND = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/aes128_round_ctrl_if.sv
// Block-side handshakes, datapath strobes and debug state of the AES-128 round controller.
interface aes128_round_ctrl_if
  import aes_ctrl_pkg::*;
#(
  parameter int RND_W = RND_W_DEF
);
  // Both handshakes transfer on a cycle where valid && ready; valid, once raised,
  // holds its payload stable until that transfer, and ready may depend on state only.
  logic             in_valid;
  logic             in_ready;
  logic             in_dec;
  logic             dp_load;
  logic             dp_init_ark;
  logic             dp_round_en;
  logic             dp_last;
  logic [RND_W-1:0] dp_rnd_idx;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [2:0]       dbg_state;

  modport slave (
    input  in_valid, in_dec, out_ready,
    output in_ready, dp_load, dp_init_ark, dp_round_en, dp_last, dp_rnd_idx,
           out_valid, busy, dbg_state
  );

  modport master (
    output in_valid, in_dec, out_ready,
    input  in_ready, dp_load, dp_init_ark, dp_round_en, dp_last, dp_rnd_idx,
           out_valid, busy, dbg_state
  );
endinterface

// File: rtl/aes_ctrl_wait_cnt.sv
// Loadable down-counter that flags the last cycle of a multi-cycle round wait.
module aes_ctrl_wait_cnt
  import aes_ctrl_pkg::*;
#(
  parameter int W = WCNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         term
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign term = (cnt == W'(1));
endmodule

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 round sequencer: accept, load, initial ARK, NR rounds, hold result.
// Define AES_CTRL_DECRYPT_EN to latch in_dec and issue key indices in inverse order.
module aes128_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NR    = AES128_NR,
  parameter int RND_W = RND_W_DEF,
  parameter int LAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  aes128_round_ctrl_if.slave  bus
);
  generate
    if (LAT < 1 || LAT > 15) begin : g_bad_lat
      $error("aes128_round_ctrl: LAT must be in 1..15");
    end
    if ((2 ** RND_W) <= NR) begin : g_bad_rnd_w
      $error("aes128_round_ctrl: RND_W too narrow for NR");
    end
  endgenerate

  localparam logic [2:0] IDLE  = S_IDLE;
  localparam logic [2:0] INIT  = S_INIT;
  localparam logic [2:0] ROUND = S_ROUND;
  localparam logic [2:0] WAIT  = S_WAIT;
  localparam logic [2:0] DONE  = S_DONE;

  localparam logic [RND_W-1:0] NR_IDX  = RND_W'(NR);
  localparam logic [RND_W-1:0] ONE_IDX = RND_W'(1);

  logic [2:0]       state, state_nxt;
  logic [RND_W-1:0] rnd, rnd_nxt;
  logic             dec_q;
  logic             accept;
  logic             last_rnd;
  logic             wait_term;

  assign accept   = (state == IDLE) && bus.in_valid && !rst;
  assign last_rnd = (rnd == NR_IDX);

  always_comb begin
    state_nxt = state;
    rnd_nxt   = rnd;
    case (state)
      IDLE: begin
        if (accept) state_nxt = INIT;
      end
      INIT: begin
        rnd_nxt   = ONE_IDX;
        state_nxt = ROUND;
      end
      ROUND: begin
        if (LAT > 1) begin
          state_nxt = WAIT;
        end else if (last_rnd) begin
          state_nxt = DONE;
        end else begin
          rnd_nxt = rnd + ONE_IDX;
        end
      end
      WAIT: begin
        if (wait_term) begin
          if (last_rnd) begin
            state_nxt = DONE;
          end else begin
            rnd_nxt   = rnd + ONE_IDX;
            state_nxt = ROUND;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rnd   <= '0;
    end else begin
      state <= state_nxt;
      rnd   <= rnd_nxt;
    end
  end

`ifdef AES_CTRL_DECRYPT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q <= 1'b0;
    end else if (accept) begin
      dec_q <= bus.in_dec;
    end
  end
`else
  logic unused_in_dec;
  assign unused_in_dec = bus.in_dec;
  assign dec_q         = 1'b0;
`endif

  // Strobes are pure state decodes; only dp_load looks at in_valid so the
  // datapath captures the block on the accept edge itself.
  always_comb begin
    bus.in_ready    = 1'b0;
    bus.dp_load     = 1'b0;
    bus.dp_init_ark = 1'b0;
    bus.dp_round_en = 1'b0;
    bus.dp_last     = 1'b0;
    bus.dp_rnd_idx  = '0;
    bus.out_valid   = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.dp_load  = bus.in_valid && !rst;
      end
      INIT: begin
        bus.dp_init_ark = 1'b1;
        bus.dp_rnd_idx  = dec_q ? NR_IDX : '0;
      end
      ROUND: begin
        bus.dp_round_en = 1'b1;
        bus.dp_last     = last_rnd;
        bus.dp_rnd_idx  = dec_q ? (NR_IDX - rnd) : rnd;
      end
      DONE: begin
        bus.out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy      = (state != IDLE);
  assign bus.dbg_state = state;

  generate
    if (LAT > 1) begin : g_wait
      logic wc_load, wc_en;
      assign wc_load = (state == ROUND);
      assign wc_en   = (state == WAIT);
      aes_ctrl_wait_cnt #(.W(WCNT_W)) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (wc_load),
        .en       (wc_en),
        .load_val (WCNT_W'(LAT - 1)),
        .term     (wait_term)
      );
    end else begin : g_no_wait
      assign wait_term = 1'b0;
    end
  endgenerate
endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Bench for aes128_round_ctrl: one LAT=1 and one LAT=3 instance, per-cycle expected strobe vectors.
module tb_aes128_round_ctrl;
  localparam int NR = 10;
`ifdef AES_CTRL_DECRYPT_EN
  localparam bit DEC_BUILD = 1'b1;
`else
  localparam bit DEC_BUILD = 1'b0;
`endif

  // Observation layout: {in_ready, busy, load, init_ark, round_en, last, idx[3:0], out_valid}
  localparam logic [10:0] FULL  = 11'h7FF;
  localparam logic [10:0] NOIDX = 11'b111_1110_0001;

  typedef struct {
    logic        in_valid;
    logic        in_dec;
    logic        out_ready;
    logic [21:0] em;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes128_round_ctrl_if #(.RND_W(4)) b1 ();
  aes128_round_ctrl_if #(.RND_W(4)) b3 ();

  aes128_round_ctrl #(.NR(NR), .RND_W(4), .LAT(1)) u_lat1 (.clk(clk), .rst(rst), .bus(b1));
  aes128_round_ctrl #(.NR(NR), .RND_W(4), .LAT(3)) u_lat3 (.clk(clk), .rst(rst), .bus(b3));

  int          checks = 0;
  int          errors = 0;
  string       tag = "reset";
  logic [22:0] exp_q[$];
  bit          count_en = 1'b0;
  int          ov_pulses = 0;
  vec_t        tbl[21];

  function automatic logic [10:0] mk(bit ir, bit bz, bit ld, bit ark, bit ren, bit last, int idx, bit ov);
    logic [3:0] i4;
    i4 = idx[3:0];
    return {ir, bz, ld, ark, ren, last, i4, ov};
  endfunction

  function automatic logic [10:0] idle_obs();
    return mk(1, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // Expected {mask, value} k cycles after the accept cycle.
  function automatic logic [21:0] exp_at(int k, int lat, bit dec);
    int j, r;
    if (k == 0) return {FULL, mk(1, 0, 1, 0, 0, 0, 0, 0)};
    if (k == 1) return {FULL, mk(0, 1, 0, 1, 0, 0, dec ? NR : 0, 0)};
    if (k >= 2 + NR * lat) return {FULL, mk(0, 1, 0, 0, 0, 0, 0, 1)};
    j = k - 2;
    r = j / lat + 1;
    if (j % lat == 0) return {FULL, mk(0, 1, 0, 0, 1, r == NR, dec ? NR - r : r, 0)};
    return {NOIDX, mk(0, 1, 0, 0, 0, 0, 0, 0)};
  endfunction

  function automatic logic [10:0] obs(bit sel);
    if (sel)
      return {b3.in_ready, b3.busy, b3.dp_load, b3.dp_init_ark, b3.dp_round_en,
              b3.dp_last, b3.dp_rnd_idx, b3.out_valid};
    return {b1.in_ready, b1.busy, b1.dp_load, b1.dp_init_ark, b1.dp_round_en,
            b1.dp_last, b1.dp_rnd_idx, b1.out_valid};
  endfunction

  always @(negedge clk) begin
    logic [22:0] e;
    logic [10:0] o, m, v;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m = e[21:11];
      v = e[10:0];
      o = obs(e[22]);
      if (m != '0) begin
        checks++;
        if ((o & m) !== (v & m)) begin
          errors++;
          $display("FAIL %s t=%0t dut%0d got %b expected %b mask %b", tag, $time, e[22], o, v, m);
        end
      end
    end
    if (count_en && b1.out_valid && b1.out_ready) ov_pulses++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(bit sel, logic v, logic d, logic r);
    if (sel) begin
      b3.in_valid = v; b3.in_dec = d; b3.out_ready = r;
    end else begin
      b1.in_valid = v; b1.in_dec = d; b1.out_ready = r;
    end
  endtask

  task automatic push(bit sel, logic [21:0] em);
    exp_q.push_back({sel, em});
  endtask

  // One block from an idle controller; hold = extra DONE cycles with out_ready low.
  task automatic run_block(bit sel, int lat, bit d, int hold);
    int last_k;
    last_k = 2 + NR * lat;
    step(); set_in(sel, 1, d, 0); push(sel, exp_at(0, lat, 0));
    for (int k = 1; k <= last_k; k++) begin
      step();
      set_in(sel, 0, 0, (hold == 0) && (k == last_k));
      push(sel, exp_at(k, lat, DEC_BUILD & d));
    end
    for (int h = 0; h < hold; h++) begin
      step(); set_in(sel, 1, 0, 0); push(sel, exp_at(last_k, lat, 0));
    end
    if (hold > 0) begin
      step(); set_in(sel, 0, 0, 1); push(sel, exp_at(last_k, lat, 0));
    end
    step(); set_in(sel, 0, 0, 0); push(sel, {FULL, idle_obs()});
    step(); push(sel, {FULL, idle_obs()});
  endtask

  initial begin
    for (int c = 0; c < 21; c++) begin
      tbl[c].in_valid  = (c == 5);
      tbl[c].in_dec    = 1'b0;
      tbl[c].out_ready = (c == 19);
      if (c < 5 || c == 20) tbl[c].em = {FULL, idle_obs()};
      else if (c <= 17)     tbl[c].em = exp_at(c - 5, 1, 0);
      else                  tbl[c].em = exp_at(12, 1, 0);
    end

    set_in(0, 0, 0, 0);
    set_in(1, 0, 0, 0);
    rst = 1'b1;
    step();
    step(); push(0, {FULL, idle_obs()});
    step(); push(1, {FULL, idle_obs()});
    step(); rst = 1'b0;

    tag = "enc_lat1_table";
    for (int c = 0; c < 21; c++) begin
      step();
      set_in(0, tbl[c].in_valid, tbl[c].in_dec, tbl[c].out_ready);
      push(0, tbl[c].em);
    end

    tag = "backpressure";
    run_block(0, 1, 0, 20);

    tag = "lat3";
    run_block(1, 3, 0, 0);

    tag = "midreset";
    step(); set_in(0, 1, 0, 0); push(0, exp_at(0, 1, 0));
    for (int k = 1; k <= 5; k++) begin
      step(); set_in(0, 0, 0, 0);
      if (k == 5) rst = 1'b1;
      push(0, exp_at(k, 1, 0));
    end
    step(); rst = 1'b0; push(0, {FULL, idle_obs()});
    for (int i = 0; i < 4; i++) begin
      step(); push(0, {FULL, idle_obs()});
    end
    tag = "after_reset_block";
    run_block(0, 1, 0, 0);

    tag = "dec_mode";
    run_block(0, 1, 1, 0);
    tag = "enc_same_build";
    run_block(0, 1, 0, 0);

    tag = "back_to_back";
    count_en = 1'b1;
    for (int c = 0; c < 52; c++) begin
      step(); set_in(0, 1, 0, 1); push(0, exp_at(c % 13, 1, 0));
    end
    step(); count_en = 1'b0; set_in(0, 0, 0, 0); push(0, {FULL, idle_obs()});
    step(); push(0, {FULL, idle_obs()});
    step();
    checks++;
    if (ov_pulses != 4) begin
      errors++;
      $display("FAIL b2b_pulses got %0d expected 4", ov_pulses);
    end

    step(); step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes128_round_ctrl.md
Name: aes128_round_ctrl

Overview:
- Iterative round sequencer for the AES-128 core.
- Accepts one block per valid/ready handshake and drives the load, initial AddRoundKey and round-enable strobes of the shared round datapath.
- Supplies the round index to the key schedule and presents the result through a valid/ready output handshake.
- Sits between the block-level I/O wrapper and the single-round datapath/key-expansion pair.

Parameters:
- NR, 10, number of full rounds; the last round omits MixColumns.
- RND_W, 4, round index width; must satisfy 2**RND_W > NR.
- LAT, 1, datapath cycles per round, legal range 1..15; LAT=0 fails an elaboration check.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  requester has a block and key ready
- in_ready  output  1  controller idle, can accept
- in_dec  input  1  mode select, sampled at accept (decrypt build only, otherwise ignored)
- dp_load  output  1  one-cycle strobe: datapath loads plaintext and key
- dp_init_ark  output  1  one-cycle strobe: initial AddRoundKey
- dp_round_en  output  1  one-cycle strobe: execute one round
- dp_last  output  1  qualifies dp_round_en: final round, skip MixColumns
- dp_rnd_idx  output  RND_W  key-schedule round index
- out_valid  output  1  result valid in datapath state register
- out_ready  input  1  consumer takes result
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0 except in_ready=1; state=IDLE, rnd=0, wcnt=0, dec_q=0.
- Reset mid-operation: return to IDLE on the next edge with no output strobes; the datapath contents are don't-care.
- IDLE:
  - in_ready=1.
  - When in_valid&in_ready: assert dp_load in the same cycle (combinational from in_valid); capture dec_q; go to INIT.
- INIT:
  - dp_init_ark=1 for one cycle; dp_rnd_idx=0.
  - rnd<=1; go to ROUND.
- ROUND:
  - dp_round_en=1 for one cycle; dp_rnd_idx=rnd; dp_last=(rnd==NR).
  - If LAT>1: wcnt<=LAT-1 and go to WAIT.
  - Else if rnd==NR go to DONE; else rnd<=rnd+1 and stay in ROUND.
- WAIT:
  - No strobes; decrement wcnt.
  - When wcnt==1: if rnd==NR go to DONE, else rnd<=rnd+1 and go to ROUND.
- DONE:
  - out_valid=1, held stable until out_ready.
  - On out_valid&out_ready go to IDLE; in_ready rises on the following cycle.
  - No same-cycle re-accept.
- in_valid outside IDLE is ignored. out_ready outside DONE is ignored.
- dp_rnd_idx=0 in IDLE and DONE. dp_last=0 whenever dp_round_en=0.
- Latency from accept edge T to out_valid: 2+NR*LAT cycles. With defaults: INIT at T+1, rounds at T+2..T+11, out_valid at T+12.
- Throughput: one block per 3+NR*LAT cycles when out_ready is held high.
- rnd is an RND_W-bit counter that never exceeds NR; no wrap is possible.

Optional Feature:
- Macro: AES_CTRL_DECRYPT_EN.
- Defined:
  - dec_q selects the inverse key order.
  - INIT drives dp_rnd_idx=NR; ROUND drives dp_rnd_idx=NR-rnd.
  - dp_last=1 at index 0.
  - Timing is identical to encrypt.
- Undefined:
  - in_dec is ignored and dec_q is tied 0.
  - Encrypt ordering only.

Decomposition:
- Package aes_ctrl_pkg holds:
  - the state enum (IDLE, INIT, ROUND, WAIT, DONE);
  - AES128_NR=10;
  - the RND_W default.
- Sub-module aes_ctrl_wait_cnt: loadable down-counter with a terminal flag, used for the WAIT state. It is instantiated only when LAT>1.

Test Plan:
- Reset then single encrypt, LAT=1: in_valid at cycle 5 -> dp_load@5, dp_init_ark@6, dp_round_en@7..16 with idx 1..10, dp_last only @16, out_valid@17.
- Back-pressure: out_ready held 0 for 20 cycles in DONE -> out_valid stays 1, in_ready stays 0, a second in_valid is ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
- LAT=3: one block -> dp_round_en pulses spaced 3 cycles apart; out_valid at T+32.
- Reset asserted at the 4th round strobe -> next cycle in_ready=1, busy=0, no further dp_round_en; a fresh block then completes normally.
- AES_CTRL_DECRYPT_EN with in_dec=1 -> INIT idx 10; rounds idx 9..0; dp_last with idx 0. Same-build encrypt block -> idx 1..10.
- Back-to-back, out_ready tied 1: 4 blocks with in_valid held 1 -> accepts spaced 13 cycles apart; exactly 4 out_valid pulses.
